// File: rtl/main_controller.sv
// VeriRISC main control unit: decodes the 6-bit opcode into registered datapath strobes.
// Optional macro CTRL_IMM_OPS_EN makes ADDI/ANDI/ORI/SLTI legal; otherwise they decode as illegal.

package main_controller_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_IMM   = 2'b11
  } alu_op_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_SLTI  = 6'b001010,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

  // All strobes low and alu_op = add: a bubble that writes nothing.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

module main_controller
  import main_controller_pkg::*;
#(
  parameter int OPW          = 6,
  parameter bit ILLEGAL_FLAG = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [OPW-1:0] opcode,
  output logic           reg_dst,
  output logic           alu_src,
  output logic           mem_to_reg,
  output logic           reg_write,
  output logic           mem_read,
  output logic           mem_write,
  output logic           branch,
  output logic           jump,
  output logic [1:0]     alu_op,
  output logic           illegal
);

`ifdef CTRL_IMM_OPS_EN
  localparam bit IMM_OPS_EN = 1'b1;
`else
  localparam bit IMM_OPS_EN = 1'b0;
`endif

  logic [5:0] op6;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;

  assign op6 = opcode[5:0];

  always_comb begin
    // NOTE: defaulting every field first keeps this block free of inferred latches.
    ctrl_d = CTRL_BUBBLE;
    case (op6)
      OP_RTYPE: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = ALU_SUB;
      end
      OP_J: begin
        ctrl_d.jump   = 1'b1;
        ctrl_d.alu_op = ALU_ADD;
      end
      OP_ADDI: begin
        if (IMM_OPS_EN) begin
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_op    = ALU_ADD;
        end else begin
          ctrl_d.illegal = ILLEGAL_FLAG;
        end
      end
      // Downstream ALU control tells ANDI/ORI/SLTI apart from the opcode bits.
      OP_ANDI, OP_ORI, OP_SLTI: begin
        if (IMM_OPS_EN) begin
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_op    = ALU_IMM;
        end else begin
          ctrl_d.illegal = ILLEGAL_FLAG;
        end
      end
      default: ctrl_d.illegal = ILLEGAL_FLAG;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      ctrl_q <= CTRL_BUBBLE;
    end else if (en) begin
      ctrl_q <= ctrl_d;
    end
  end

  assign reg_dst    = ctrl_q.reg_dst;
  assign alu_src    = ctrl_q.alu_src;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign branch     = ctrl_q.branch;
  assign jump       = ctrl_q.jump;
  assign alu_op     = ctrl_q.alu_op;
  assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_main_controller.sv
// Self-checking bench for main_controller: directed cases plus randomized opcodes/enable/reset
// compared against a table-driven reference of the decode map.

module tb_main_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [5:0] opcode;
  logic       reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
  logic       branch, jump, illegal;
  logic [1:0] alu_op;

  int n_cmp = 0;
  int n_bad = 0;

  // Packed view: {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_op, illegal}
  logic [10:0] obs;
  logic [10:0] model;
  logic [10:0] ref_tab [int];

  assign obs = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                branch, jump, alu_op, illegal};

  main_controller #(.OPW(6), .ILLEGAL_FLAG(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .opcode     (opcode),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .branch     (branch),
    .jump       (jump),
    .alu_op     (alu_op),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [10:0] mk(bit rd, bit as, bit m2r, bit rw, bit mrd, bit mw,
                                     bit br, bit j, logic [1:0] op);
    return {rd, as, m2r, rw, mrd, mw, br, j, op, 1'b0};
  endfunction

  // Anything missing from the table is an illegal bubble.
  function automatic logic [10:0] ref_ctrl(input logic [5:0] op);
    if (ref_tab.exists(int'(op))) return ref_tab[int'(op)];
    return 11'b000_0000_0001;
  endfunction

  task automatic build_table();
    ref_tab[6'b000000] = mk(1, 0, 0, 1, 0, 0, 0, 0, 2'b10);
    ref_tab[6'b100011] = mk(0, 1, 1, 1, 1, 0, 0, 0, 2'b00);
    ref_tab[6'b101011] = mk(0, 1, 0, 0, 0, 1, 0, 0, 2'b00);
    ref_tab[6'b000100] = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b01);
    ref_tab[6'b000010] = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00);
`ifdef CTRL_IMM_OPS_EN
    ref_tab[6'b001000] = mk(0, 1, 0, 1, 0, 0, 0, 0, 2'b00);
    ref_tab[6'b001100] = mk(0, 1, 0, 1, 0, 0, 0, 0, 2'b11);
    ref_tab[6'b001101] = mk(0, 1, 0, 1, 0, 0, 0, 0, 2'b11);
    ref_tab[6'b001010] = mk(0, 1, 0, 1, 0, 0, 0, 0, 2'b11);
`endif
  endtask

  // Advance one rising edge, update the model from the inputs present at that edge,
  // and return 1 time unit later for sampling.
  task automatic tick();
    @(posedge clk);
    if (reset && en) model = ref_ctrl(opcode);
    #1;
  endtask

  task automatic check_invariants(input string tag);
    check({tag, "_rd_wr_excl"}, 32'(mem_read & mem_write), 32'd0);
    check({tag, "_rw_excl"}, 32'(reg_write & (mem_write | branch | jump)), 32'd0);
    check({tag, "_illegal_alone"},
          32'(illegal & (reg_dst | alu_src | mem_to_reg | reg_write | mem_read |
                         mem_write | branch | jump | (|alu_op))), 32'd0);
  endtask

  logic [5:0] op_pool [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                              6'b001000, 6'b001100, 6'b001101, 6'b001010};

  initial begin
    build_table();
    reset  = 1'b0;
    en     = 1'b1;
    opcode = 6'b000000;
    model  = '0;

    // Reset held with clock running: outputs stay zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", 32'(obs), 32'd0);
    end
    reset = 1'b1;
    tick();
    check("rtype_after_reset", 32'(obs), 32'(mk(1, 0, 0, 1, 0, 0, 0, 0, 2'b10)));

    // Load/store.
    opcode = 6'b100011; tick();
    check("lw", 32'(obs), 32'(mk(0, 1, 1, 1, 1, 0, 0, 0, 2'b00)));
    opcode = 6'b101011; tick();
    check("sw", 32'(obs), 32'(mk(0, 1, 0, 0, 0, 1, 0, 0, 2'b00)));

    // Branch and jump.
    opcode = 6'b000100; tick();
    check("beq", 32'(obs), 32'(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b01)));
    opcode = 6'b000010; tick();
    check("j", 32'(obs), 32'(mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00)));

    // Illegal and optional immediate opcodes.
    opcode = 6'b111111; tick();
    check("illegal_3f", 32'(obs), 32'd1);
    opcode = 6'b001000; tick();
`ifdef CTRL_IMM_OPS_EN
    check("addi", 32'(obs), 32'(mk(0, 1, 0, 1, 0, 0, 0, 0, 2'b00)));
`else
    check("addi_illegal", 32'(obs), 32'd1);
`endif

    // Hold and latency.
    opcode = 6'b100011; tick();
    check("hold_lw_load", 32'(obs), 32'(mk(0, 1, 1, 1, 1, 0, 0, 0, 2'b00)));
    en = 1'b0; opcode = 6'b101011;
    tick(); check("hold_1", 32'(obs), 32'(mk(0, 1, 1, 1, 1, 0, 0, 0, 2'b00)));
    tick(); check("hold_2", 32'(obs), 32'(mk(0, 1, 1, 1, 1, 0, 0, 0, 2'b00)));
    en = 1'b1; #2;
    check("no_early_update", 32'(obs), 32'(mk(0, 1, 1, 1, 1, 0, 0, 0, 2'b00)));
    tick();
    check("sw_after_enable", 32'(obs), 32'(mk(0, 1, 0, 0, 0, 1, 0, 0, 2'b00)));

    // Async reset between edges while decoding LW.
    opcode = 6'b100011; tick();
    check("lw_before_async", 32'(obs), 32'(mk(0, 1, 1, 1, 1, 0, 0, 0, 2'b00)));
    #2 reset = 1'b0;
    #1 check("async_reset", 32'(obs), 32'd0);
    model = '0;
    #1 reset = 1'b1;

    // Randomized opcodes, enable and occasional mid-cycle reset pulses.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) opcode = 6'($urandom());
      else                           opcode = op_pool[$urandom_range(0, 8)];
      if ($urandom_range(0, 24) == 0) begin
        #2 reset = 1'b0;
        #1 check("rand_async_reset", 32'(obs), 32'd0);
        model = '0;
        #1 reset = 1'b1;
      end
      tick();
      check("rand", 32'(obs), 32'(model));
      check_invariants("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/main_controller.md
Name:
main_controller

Overview:
- Main control unit for the VeriRISC single-issue, MIPS-style datapath.
- Decodes the 6-bit instruction opcode into datapath control strobes and a 2-bit ALU operation class.
- Outputs are registered: one clock of latency from opcode to control.
- Sits between instruction fetch/IR and the register file, ALU, data memory and PC-select logic.

Parameters:
- OPW, 6, opcode width in bits; must be 6 for the standard opcode map.
- ILLEGAL_FLAG, 1, when 1 the illegal output flags undefined opcodes; when 0 illegal is tied to 0.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; asserted when 0
- en  input  1  decode enable; when 0 all outputs hold their value
- opcode  input  OPW  instruction bits [31:26]
- reg_dst  output  1  1 selects rd as write register, 0 selects rt
- alu_src  output  1  1 selects the sign-extended immediate as ALU operand B
- mem_to_reg  output  1  1 selects the memory read data for register writeback
- reg_write  output  1  register file write enable
- mem_read  output  1  data memory read enable
- mem_write  output  1  data memory write enable
- branch  output  1  conditional branch (BEQ) request
- jump  output  1  unconditional jump request
- alu_op  output  2  00 = add, 01 = subtract/compare, 10 = use funct field, 11 = immediate logic/compare
- illegal  output  1  opcode not in the decode map

Behaviour:
- Reset: while reset is 0, every output is 0, immediately and asynchronously, including alu_op = 00. Asserting reset at any time overrides everything. The first decode happens at the first rising edge after reset returns to 1.
- Decode is combinational from opcode. The result is registered on the rising edge of clk when en = 1, so outputs reflect the opcode sampled at the previous edge (latency 1). When en = 0, the registers hold.
- Decode map; any signal not listed is 0:
  - 000000 R-type: reg_dst = 1, reg_write = 1, alu_op = 10.
  - 100011 LW: alu_src = 1, mem_to_reg = 1, reg_write = 1, mem_read = 1, alu_op = 00.
  - 101011 SW: alu_src = 1, mem_write = 1, alu_op = 00. reg_write is 0.
  - 000100 BEQ: branch = 1, alu_op = 01.
  - 000010 J: jump = 1, alu_op = 00.
  - Any other opcode: all strobes 0, alu_op = 00, illegal = 1 (if ILLEGAL_FLAG = 1). The instruction is a bubble: no writes of any kind.
- Invariants for every opcode:
  - mem_read and mem_write are never both 1.
  - reg_write is 0 whenever mem_write, branch or jump is 1.
  - illegal is 1 only when all other strobes are 0.
- Back-to-back opcode changes are decoded independently each enabled cycle; there is no internal state beyond the output registers.

Optional Feature:
- Macro: CTRL_IMM_OPS_EN.
- When defined, these immediate ALU opcodes are legal:
  - 001000 ADDI: alu_src = 1, reg_write = 1, alu_op = 00.
  - 001100 ANDI, 001101 ORI, 001010 SLTI: alu_src = 1, reg_write = 1, alu_op = 11. Downstream ALU control distinguishes these using opcode bits.
  - reg_dst = 0 for all four.
- When not defined, these four opcodes decode as illegal (all strobes 0, illegal = 1).

Test Plan:
- Reset check: reset = 0 with opcode = 000000 and clock running -> all outputs 0 for every cycle. Release reset, then one edge -> reg_dst = 1, alu_src = 0, reg_write = 1, alu_op = 10.
- Load/store decode: opcode = 100011, one edge -> alu_src = 1, mem_read = 1, mem_to_reg = 1, reg_write = 1, mem_write = 0. Then opcode = 101011, one edge -> alu_src = 1, mem_write = 1, reg_write = 0, mem_read = 0.
- Branch and jump decode: opcode = 000100 -> branch = 1, alu_op = 01, reg_write = 0. Then opcode = 000010 -> jump = 1, branch = 0.
- Illegal opcode: opcode = 111111 -> illegal = 1, all strobes 0. With CTRL_IMM_OPS_EN undefined, opcode = 001000 -> illegal = 1. With it defined -> alu_src = 1, reg_write = 1, alu_op = 00.
- Hold and latency: set en = 0, change opcode from LW to SW -> outputs stay at LW values. Set en = 1 -> SW values appear after exactly one edge, not before.
- Async reset mid-operation: assert reset between clock edges while decoding LW -> outputs go to 0 before the next edge.
